// File: rtl/nn_input_feeder_if.sv
// Request, channel-write, ROM-write and status signals of the NN input feeder.
// The feeder is the slave; whatever drives requests and ROM writes is the master.
interface nn_input_feeder_if #(
  parameter int DATA_W    = 8,
  parameter int N_INPUTS  = 2,
  parameter int N_SAMPLES = 4
);
  localparam int ADDR_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int SAMPLE_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int ROM_AW   = (N_INPUTS * N_SAMPLES > 1) ? $clog2(N_INPUTS * N_SAMPLES) : 1;

  logic                       start;
  logic [SAMPLE_W-1:0]        sample_sel;
  logic                       fill;
  logic                       wr_trig;
  logic [ADDR_W-1:0]          wr_abus;
  logic signed [DATA_W-1:0]   wr_dbus;
  logic                       ack;
  logic                       busy;
  logic                       rom_we;
  logic [ROM_AW-1:0]          rom_waddr;
  logic signed [DATA_W-1:0]   rom_wdata;
  logic                       err;

  modport slave (
    input  start, sample_sel, fill, rom_we, rom_waddr, rom_wdata,
    output wr_trig, wr_abus, wr_dbus, ack, busy, err
  );

  modport master (
    output start, sample_sel, fill, rom_we, rom_waddr, rom_wdata,
    input  wr_trig, wr_abus, wr_dbus, ack, busy, err
  );
endinterface

// File: rtl/nn_input_feeder.sv
// Input stage for the NN top: streams one stored sample vector from a run-time
// writable ROM into the layer-0 channel memory, then acks to start layer 0.
//   state   | meaning
//   IDLE    | nothing streamed since reset, ack low
//   LOAD    | issuing one channel write per cycle while fill is high
//   DONE    | vector complete, ack held high until the next accepted start
module nn_input_feeder #(
  parameter int DATA_W    = 8,
  parameter int N_INPUTS  = 2,
  parameter int N_SAMPLES = 4,
  parameter int INIT_VAL  = 16
) (
  input logic              clk,
  input logic              rst,
  nn_input_feeder_if.slave bus
);
  localparam int TOTAL  = N_INPUTS * N_SAMPLES;
  localparam int ADDR_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int ROM_AW = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

  state_t                    r_state;
  logic [ADDR_W-1:0]         r_idx;
  logic [ROM_AW-1:0]         r_base;
  logic                      r_wr_trig;
  logic [ADDR_W-1:0]         r_wr_abus;
  logic signed [DATA_W-1:0]  r_wr_dbus;
  logic                      r_ack;
  logic                      r_busy;
  logic                      r_err;

  // Contents survive rst; only the power-up image is INIT_VAL.
  logic signed [DATA_W-1:0]  r_rom [TOTAL] = '{default: DATA_W'(INIT_VAL)};

  logic                      w_busy;
  logic                      w_sel_ok;
  logic                      w_start_ok;
  logic                      w_start_err;
  logic                      w_rom_ok;
  logic                      w_rom_err;
  logic [ROM_AW-1:0]         w_raddr;
  logic [ROM_AW-1:0]         w_base_nxt;
  logic                      w_last;

  assign w_busy      = (r_state == ST_LOAD);
  assign w_sel_ok    = (32'(bus.sample_sel) < N_SAMPLES);
  assign w_start_ok  = bus.start && !w_busy && w_sel_ok;
  assign w_start_err = bus.start && (w_busy || !w_sel_ok);
  assign w_rom_ok    = bus.rom_we && !w_busy && (32'(bus.rom_waddr) < TOTAL);
  assign w_rom_err   = bus.rom_we && !w_rom_ok;
  assign w_raddr     = r_base + ROM_AW'(r_idx);
  assign w_base_nxt  = ROM_AW'(32'(bus.sample_sel) * N_INPUTS);
  assign w_last      = (r_idx == ADDR_W'(N_INPUTS - 1));

  // Writes are locked out during LOAD so a streamed vector is never torn.
  always_ff @(posedge clk) begin
    if (w_rom_ok) begin
      r_rom[bus.rom_waddr] <= bus.rom_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_base    <= '0;
      r_wr_trig <= 1'b0;
      r_wr_abus <= '0;
      r_wr_dbus <= '0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err     <= w_start_err || w_rom_err;
      r_wr_trig <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (r_state == ST_DONE) begin
            r_ack <= 1'b1;
          end
          if (w_start_ok) begin
            r_base  <= w_base_nxt;
            r_idx   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (bus.fill) begin
            r_wr_trig <= 1'b1;
            r_wr_abus <= r_idx;
            r_wr_dbus <= r_rom[w_raddr];
            r_idx     <= r_idx + 1'b1;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.wr_trig = r_wr_trig;
  assign bus.wr_abus = r_wr_abus;
  assign bus.wr_dbus = r_wr_dbus;
  assign bus.ack     = r_ack;
  assign bus.busy    = r_busy;
  assign bus.err     = r_err;
endmodule
